// File: rtl/perceptron_backprop.sv
// Q32.32 perceptron training-update engine: forms delta from y/target, then
// streams N weights through w' = w + lr*delta*x and emits the updated bias.

module perceptron_backprop_mul #(
  parameter int FRAC_BITS = 32
) (
  input  logic signed [63:0] a,
  input  logic signed [63:0] b,
  output logic signed [63:0] p
);
  logic signed [127:0] a_ext, b_ext, prod;
  logic                unused_prod;

  assign a_ext = {{64{a[63]}}, a};
  assign b_ext = {{64{b[63]}}, b};
  assign prod  = a_ext * b_ext;
  // Taking the slice is the arithmetic shift plus truncation to 64 bits.
  assign p     = prod[FRAC_BITS +: 64];
  assign unused_prod = ^{prod[127:FRAC_BITS+64], prod[FRAC_BITS-1:0]};
endmodule

module perceptron_backprop #(
  parameter int N_INPUTS  = 4,
  parameter int FRAC_BITS = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      act,
  input  logic [63:0]                     y,
  input  logic [63:0]                     target,
  input  logic [63:0]                     lr,
  input  logic [63:0]                     bias_in,
  input  logic [63:0]                     x_in,
  input  logic [63:0]                     w_in,
  input  logic                            xw_valid,
  output logic                            xw_ready,
  output logic [63:0]                     w_out,
  output logic [$clog2(N_INPUTS+1)-1:0]   w_idx,
  output logic                            w_last,
  output logic                            w_valid,
  input  logic                            w_ready,
  output logic [63:0]                     delta_out,
  output logic                            busy,
  output logic                            done
);
  localparam int IW = $clog2(N_INPUTS + 1);
  localparam logic signed [63:0] ONE = 64'sd1 <<< FRAC_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_DELTA, S_SCALE, S_STREAM, S_BIAS, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ACT_STEP = 2'd0, ACT_SIG = 2'd1, ACT_TANH = 2'd2, ACT_RELU = 2'd3
  } act_t;

  state_t state, nstate;

  logic signed [63:0] y_r, target_r, lr_r, bias_r;
  logic signed [63:0] err_r, d_r, scale_r;
  logic        [1:0]  act_r;
  logic      [IW-1:0] cnt;
  logic               bias_loaded;

  logic signed [63:0] mul_a, mul_b, mul_p;
  logic               beat_acc, out_free, last_beat, bias_load;

  assign out_free  = ~w_valid | w_ready;
  assign beat_acc  = xw_valid & xw_ready;
  assign last_beat = (cnt == IW'(N_INPUTS - 1));
  assign bias_load = (state == S_BIAS) & ~bias_loaded & out_free;

  // Single multiplier, time-shared across the sequential phases.
  always_comb begin
    mul_a = scale_r;
    mul_b = x_in;
    case (state)
      S_ERR: begin
        mul_a = y_r;
        mul_b = (act_r == ACT_SIG) ? (ONE - y_r) : y_r;
      end
      S_DELTA: begin
        mul_a = err_r;
        mul_b = d_r;
      end
      S_SCALE: begin
        mul_a = lr_r;
        mul_b = delta_out;
      end
      default: ;
    endcase
  end

  perceptron_backprop_mul #(.FRAC_BITS(FRAC_BITS)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   if (start) nstate = S_ERR;
      S_ERR:    nstate = S_DELTA;
      S_DELTA:  nstate = S_SCALE;
      S_SCALE:  nstate = S_STREAM;
      S_STREAM: if (beat_acc && last_beat) nstate = S_BIAS;
      S_BIAS:   if (bias_loaded && w_valid && w_ready) nstate = S_DONE;
      S_DONE:   nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  always_comb begin
    xw_ready = (state == S_STREAM) & out_free;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r       <= '0;
      target_r  <= '0;
      lr_r      <= '0;
      bias_r    <= '0;
      act_r     <= '0;
      err_r     <= '0;
      d_r       <= '0;
      scale_r   <= '0;
      delta_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          y_r      <= y;
          target_r <= target;
          lr_r     <= lr;
          bias_r   <= bias_in;
          act_r    <= act;
        end
        S_ERR: begin
          err_r <= target_r - y_r;
          case (act_r)
            ACT_STEP: d_r <= ONE;
            ACT_SIG:  d_r <= mul_p;
            ACT_TANH: d_r <= ONE - mul_p;
            default:  d_r <= (y_r > 64'sd0) ? ONE : 64'sd0;
          endcase
        end
        S_DELTA: delta_out <= mul_p;
        S_SCALE: scale_r   <= mul_p;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      bias_loaded <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        cnt         <= '0;
        bias_loaded <= 1'b0;
      end else begin
        if (beat_acc)  cnt         <= cnt + 1'b1;
        if (bias_load) bias_loaded <= 1'b1;
      end
    end
  end

  // Single-entry output register; contents only change when it is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_out   <= '0;
      w_idx   <= '0;
      w_last  <= 1'b0;
      w_valid <= 1'b0;
    end else if (beat_acc) begin
      w_out   <= w_in + mul_p;
      w_idx   <= cnt;
      w_last  <= 1'b0;
      w_valid <= 1'b1;
    end else if (bias_load) begin
      w_out   <= bias_r + scale_r;
      w_idx   <= IW'(N_INPUTS);
      w_last  <= 1'b1;
      w_valid <= 1'b1;
    end else if (w_ready) begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end
  end
endmodule
